// File: rtl/lfsr_way_replacer_if.sv
// Request/response bundle between the miss handler (master) and the
// replacement-way selector (slave).
interface lfsr_way_replacer_if #(
  parameter int NUM_WAYS = 4,
  parameter int WAY_BITS = $clog2(NUM_WAYS)
) ();
  logic                req;
  logic [NUM_WAYS-1:0] valid_mask;
  logic [NUM_WAYS-1:0] lock_mask;
  logic                resp_valid;
  logic [WAY_BITS-1:0] resp_way;
  logic [NUM_WAYS-1:0] resp_onehot;
  logic                resp_fill;
  logic                resp_none;

  modport master (
    output req, valid_mask, lock_mask,
    input  resp_valid, resp_way, resp_onehot, resp_fill, resp_none
  );

  modport slave (
    input  req, valid_mask, lock_mask,
    output resp_valid, resp_way, resp_onehot, resp_fill, resp_none
  );
endinterface

// File: rtl/lfsr_way_replacer.sv
// Pseudo-random replacement-way selector: invalid-way-first fill, lock-aware
// Galois-LFSR rotation. Define LFSR_WAY_REPLACER_PERF_EN for saturating perf counters.
module lfsr_way_replacer #(
  parameter int                 WIDTH    = 16,
  parameter logic [WIDTH-1:0]   TAPS     = 16'hB400,
  parameter int                 NUM_WAYS = 4,
  parameter int                 WAY_BITS = $clog2(NUM_WAYS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 seed_we,
  input  logic [WIDTH-1:0]     seed_data,
  lfsr_way_replacer_if.slave   bus,
  output logic [WIDTH-1:0]     lfsr_q
`ifdef LFSR_WAY_REPLACER_PERF_EN
  ,
  output logic [31:0]          perf_fill_cnt,
  output logic [31:0]          perf_rand_cnt,
  output logic [31:0]          perf_none_cnt
`endif
);

  logic [WIDTH-1:0]    lfsr_d;
  logic [WIDTH-1:0]    lfsr_step;
  logic [WAY_BITS-1:0] start;
  logic [WAY_BITS-1:0] scan_idx [NUM_WAYS];
  logic [WAY_BITS-1:0] fill_way;
  logic [WAY_BITS-1:0] rand_way;
  logic                any_invalid;
  logic                any_unlocked;

  logic                resp_valid_q, resp_valid_d;
  logic [WAY_BITS-1:0] resp_way_q, resp_way_d;
  logic [NUM_WAYS-1:0] resp_onehot_q, resp_onehot_d;
  logic                resp_fill_q, resp_fill_d;
  logic                resp_none_q, resp_none_d;

  assign lfsr_step = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
  assign start     = lfsr_q[WAY_BITS-1:0];

  // Candidate order for the random path: start, start+1, ... wrapping mod NUM_WAYS.
  for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_scan
    assign scan_idx[gi] = start + WAY_BITS'(gi);
  end

  always_comb begin
    fill_way     = '0;
    any_invalid  = 1'b0;
    rand_way     = '0;
    any_unlocked = 1'b0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (!bus.valid_mask[i]) begin
        any_invalid = 1'b1;
        fill_way    = WAY_BITS'(i);
      end
    end
    for (int k = NUM_WAYS - 1; k >= 0; k--) begin
      if (!bus.lock_mask[scan_idx[k]]) begin
        any_unlocked = 1'b1;
        rand_way     = scan_idx[k];
      end
    end
  end

  always_comb begin
    resp_valid_d  = bus.req;
    resp_fill_d   = bus.req && any_invalid;
    resp_none_d   = bus.req && !any_invalid && !any_unlocked;
    resp_way_d    = '0;
    resp_onehot_d = '0;
    if (bus.req && any_invalid) begin
      resp_way_d = fill_way;
    end else if (bus.req && any_unlocked) begin
      resp_way_d = rand_way;
    end
    if (bus.req && !resp_none_d) begin
      resp_onehot_d = NUM_WAYS'(1) << resp_way_d;
    end

    // Seed wins over the advance; selection above already used the old state.
    lfsr_d = lfsr_q;
    if (seed_we) begin
      lfsr_d = (seed_data == '0) ? WIDTH'(1) : seed_data;
    end else if (bus.req && !any_invalid) begin
      lfsr_d = lfsr_step;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q        <= WIDTH'(1);
      resp_valid_q  <= 1'b0;
      resp_way_q    <= '0;
      resp_onehot_q <= '0;
      resp_fill_q   <= 1'b0;
      resp_none_q   <= 1'b0;
    end else begin
      lfsr_q        <= lfsr_d;
      resp_valid_q  <= resp_valid_d;
      resp_way_q    <= resp_way_d;
      resp_onehot_q <= resp_onehot_d;
      resp_fill_q   <= resp_fill_d;
      resp_none_q   <= resp_none_d;
    end
  end

  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_way    = resp_way_q;
  assign bus.resp_onehot = resp_onehot_q;
  assign bus.resp_fill   = resp_fill_q;
  assign bus.resp_none   = resp_none_q;

`ifdef LFSR_WAY_REPLACER_PERF_EN
  logic [31:0] perf_fill_q, perf_fill_d;
  logic [31:0] perf_rand_q, perf_rand_d;
  logic [31:0] perf_none_q, perf_none_d;
  logic        rand_hit;

  assign rand_hit = bus.req && !any_invalid && any_unlocked;

  always_comb begin
    perf_fill_d = perf_fill_q;
    perf_rand_d = perf_rand_q;
    perf_none_d = perf_none_q;
    if (resp_fill_d && (perf_fill_q != 32'hFFFF_FFFF)) perf_fill_d = perf_fill_q + 32'd1;
    if (rand_hit    && (perf_rand_q != 32'hFFFF_FFFF)) perf_rand_d = perf_rand_q + 32'd1;
    if (resp_none_d && (perf_none_q != 32'hFFFF_FFFF)) perf_none_d = perf_none_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fill_q <= '0;
      perf_rand_q <= '0;
      perf_none_q <= '0;
    end else begin
      perf_fill_q <= perf_fill_d;
      perf_rand_q <= perf_rand_d;
      perf_none_q <= perf_none_d;
    end
  end

  assign perf_fill_cnt = perf_fill_q;
  assign perf_rand_cnt = perf_rand_q;
  assign perf_none_cnt = perf_none_q;
`endif

endmodule
